// File: rtl/lap_seq_pkg.sv
// lap_seq_pkg: shared FSM state and command types for lap_sequencer.
// cmd_decode folds the three buttons into one command, stop > start > lap.
package lap_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_REVIEW
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_START,
    CMD_LAP
  } cmd_e;

  function automatic cmd_e cmd_decode(
    input logic stop,
    input logic start,
    input logic lap
  );
    cmd_e c;
    priority case (1'b1)
      stop:    c = CMD_STOP;
      start:   c = CMD_START;
      lap:     c = CMD_LAP;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lap_sequencer_if.sv
// lap_sequencer_if: button/time inputs and run/hold/clear/display outputs.
// master drives buttons and time_val; slave (the sequencer) drives the rest.
interface lap_sequencer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              btn_start;
  logic              btn_lap;
  logic              btn_stop;
  logic [DATA_W-1:0] time_val;
  logic              run;
  logic              hold;
  logic              clear;
  logic [DATA_W-1:0] disp_val;
  logic [AW-1:0]     disp_idx;
  logic [AW:0]       lap_cnt;
  logic              full;
  logic              ovf;

  modport master (
    output btn_start, btn_lap, btn_stop, time_val,
    input  run, hold, clear, disp_val, disp_idx,
    input  lap_cnt, full, ovf
  );

  modport slave (
    input  btn_start, btn_lap, btn_stop, time_val,
    output run, hold, clear, disp_val, disp_idx,
    output lap_cnt, full, ovf
  );

endinterface

// File: rtl/lap_ram.sv
// lap_ram: DEPTH x DATA_W lap storage, sync write, registered read.
// Ports: clk, we/wr_addr/wr_data, re/rd_addr/rd_data. No reset on contents.
module lap_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lap_sequencer.sv
// lap_sequencer: stopwatch lap capture and timed review playback.
// Ports: clk, rst (async, active-low), bus (lap_sequencer_if.slave).
// Option: LAP_SEQ_AUTOSTOP_EN moves RUN to REVIEW on the filling lap.
module lap_sequencer #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int PLAY_CYCLES = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  lap_sequencer_if.slave bus
);
  import lap_seq_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int DW_W = (PLAY_CYCLES > 1) ? $clog2(PLAY_CYCLES) : 1;
  localparam logic [AW:0]     CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(PLAY_CYCLES - 1);

  state_e            state_q, state_d;
  cmd_e              cmd;
  logic [AW-1:0]     wr_ptr, rd_ptr, disp_idx_q;
  logic [AW:0]       lap_cnt_q;
  logic [DW_W-1:0]   dwell_q;
  logic              ovf_q, clear_q, shown_q;
  logic              full;
  logic              lap_we, ovf_set, laps_clr, start_clr;
  logic              rev_enter, rd_en;
  state_e            stop_dst;
  logic [DATA_W-1:0] rd_data;

  assign cmd      = cmd_decode(bus.btn_stop, bus.btn_start, bus.btn_lap);
  assign full     = (lap_cnt_q == CNT_FULL);
  assign stop_dst = (lap_cnt_q != '0) ? S_REVIEW : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    lap_we    = 1'b0;
    ovf_set   = 1'b0;
    laps_clr  = 1'b0;
    start_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd == CMD_START) begin
          state_d   = S_RUN;
          start_clr = 1'b1;
          laps_clr  = 1'b1;
        end
      end
      S_RUN: begin
        unique case (cmd)
          CMD_STOP:  state_d = stop_dst;
          CMD_START: state_d = S_PAUSE;
          CMD_LAP: begin
            if (full) begin
              ovf_set = 1'b1;
            end else begin
              lap_we = 1'b1;
`ifdef LAP_SEQ_AUTOSTOP_EN
              if (lap_cnt_q == CNT_LAST) state_d = S_REVIEW;
`else
              state_d = S_RUN;
`endif
            end
          end
          default: state_d = S_RUN;
        endcase
      end
      S_PAUSE: begin
        unique case (cmd)
          CMD_STOP:  state_d = stop_dst;
          CMD_START: state_d = S_RUN;
          default:   state_d = S_PAUSE;
        endcase
      end
      S_REVIEW: begin
        if (cmd == CMD_STOP) begin
          state_d  = S_IDLE;
          laps_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rev_enter = (state_d == S_REVIEW) && (state_q != S_REVIEW);
  assign rd_en     = (state_q == S_REVIEW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lap_cnt_q  <= '0;
      dwell_q    <= '0;
      ovf_q      <= 1'b0;
      clear_q    <= 1'b0;
      shown_q    <= 1'b0;
      disp_idx_q <= '0;
    end else begin
      clear_q <= start_clr;
      if (laps_clr) begin
        wr_ptr    <= '0;
        lap_cnt_q <= '0;
      end else if (lap_we) begin
        wr_ptr    <= wr_ptr + 1'b1;
        lap_cnt_q <= lap_cnt_q + 1'b1;
      end
      if (start_clr)    ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (rev_enter) begin
        rd_ptr  <= '0;
        dwell_q <= '0;
      end else if (rd_en) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_q <= '0;
          // wrap at the last stored lap, not at DEPTH-1
          if (({1'b0, rd_ptr} + 1'b1) == lap_cnt_q) rd_ptr <= '0;
          else rd_ptr <= rd_ptr + 1'b1;
        end else begin
          dwell_q <= dwell_q + 1'b1;
        end
      end
      // index follows the read so it lines up with rd_data
      if (rd_en) begin
        disp_idx_q <= rd_ptr;
        shown_q    <= 1'b1;
      end
    end
  end

  lap_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we      (lap_we),
    .wr_addr (wr_ptr),
    .wr_data (bus.time_val),
    .re      (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // RAM output is unreset, so mask it until a read has happened
  assign bus.disp_val = shown_q ? rd_data : '0;
  assign bus.disp_idx = disp_idx_q;
  assign bus.run      = (state_q == S_RUN);
  assign bus.hold     = (state_q == S_PAUSE);
  assign bus.clear    = clear_q;
  assign bus.lap_cnt  = lap_cnt_q;
  assign bus.full     = full;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_lap_sequencer.sv
// tb_lap_sequencer: vector table plus scoreboarded review sequences.
// DEPTH=4, PLAY_CYCLES=4; AUTOSTOP expectations follow the macro.
module tb_lap_sequencer;
  import lap_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int PC    = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] sb [$];

  lap_sequencer_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

  lap_sequencer #(
    .DEPTH       (DEPTH),
    .DATA_W      (DW),
    .PLAY_CYCLES (PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stop;
    logic       start;
    logic       lap;
    logic [7:0] tv;
    logic       wr;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(
    input logic s, input logic st, input logic l,
    input logic [7:0] tv, input logic wr,
    input state_e es, input logic r, input logic h,
    input logic c, input logic f, input logic o,
    input logic [2:0] n
  );
    vec_t v;
    v.stop  = s;
    v.start = st;
    v.lap   = l;
    v.tv    = tv;
    v.wr    = wr;
    v.exp   = {es, r, h, c, f, o, n};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic s, input logic st, input logic l,
    input logic [7:0] tv
  );
    bus.btn_stop  = s;
    bus.btn_start = st;
    bus.btn_lap   = l;
    bus.time_val  = tv;
    tick();
    bus.btn_stop  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
  endtask

  task automatic check(
    input string name, input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input int idx);
    logic [DW-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      sb.push_back(e);
      check(name, 32'(bus.disp_val), 32'(e));
      check({name, "_idx"}, 32'(bus.disp_idx), 32'(idx));
    end
  endtask

  // first check one cycle after REVIEW entry, then once per dwell
  task automatic review_seq(input string name, input int n);
    int nl;
    nl = sb.size();
    tick();
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat (PC) tick();
      check_disp($sformatf("%s_%0d", name, k), k % nl);
    end
  endtask

  function automatic logic [9:0] obs();
    return {dut.state_q, bus.run, bus.hold, bus.clear,
            bus.full, bus.ovf, bus.lap_cnt};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
    bus.time_val  = '0;

    tbl[0] = mk(0,1,0,8'd0, 0,S_RUN,  1,0,1,0,0,3'd0);
    tbl[1] = mk(0,1,0,8'd0, 0,S_PAUSE,0,1,0,0,0,3'd0);
    tbl[2] = mk(0,0,1,8'd77,0,S_PAUSE,0,1,0,0,0,3'd0);
    tbl[3] = mk(0,1,0,8'd0, 0,S_RUN,  1,0,0,0,0,3'd0);
    tbl[4] = mk(0,0,0,8'd0, 0,S_RUN,  1,0,0,0,0,3'd0);
    tbl[5] = mk(0,0,1,8'd11,1,S_RUN,  1,0,0,0,0,3'd1);
    tbl[6] = mk(0,0,1,8'd22,1,S_RUN,  1,0,0,0,0,3'd2);
    tbl[7] = mk(0,0,1,8'd33,1,S_RUN,  1,0,0,0,0,3'd3);
`ifdef LAP_SEQ_AUTOSTOP_EN
    tbl[8]  = mk(0,0,1,8'd44,1,S_REVIEW,0,0,0,1,0,3'd4);
    tbl[9]  = mk(0,0,1,8'd55,0,S_REVIEW,0,0,0,1,0,3'd4);
    tbl[10] = mk(1,0,0,8'd0, 0,S_IDLE,  0,0,0,0,0,3'd0);
`else
    tbl[8]  = mk(0,0,1,8'd44,1,S_RUN,   1,0,0,1,0,3'd4);
    tbl[9]  = mk(0,0,1,8'd55,0,S_RUN,   1,0,0,1,1,3'd4);
    tbl[10] = mk(1,0,0,8'd0, 0,S_REVIEW,0,0,0,1,1,3'd4);
`endif

    // reset state
    repeat (2) tick();
    check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rst_outs", 32'(obs()), 32'd0);
    check("rst_disp", {bus.disp_val, 8'(bus.disp_idx)}, 32'd0);
    rst = 1'b1;
    tick();

    // three laps then review with wrap
    sb.delete();
    drive(0, 1, 0, 8'd0);
    check("start_run", 32'({bus.run, bus.clear}), 32'b11);
    drive(0, 0, 1, 8'd5);  sb.push_back(8'd5);
    drive(0, 0, 1, 8'd9);  sb.push_back(8'd9);
    drive(0, 0, 1, 8'd14); sb.push_back(8'd14);
    check("three_laps", 32'({bus.full, bus.lap_cnt}), 32'd3);
    drive(1, 0, 0, 8'd0);
    check("stop_review", 32'({dut.state_q, bus.run}), 32'({S_REVIEW, 1'b0}));
    review_seq("rev3", 4);

    // reset held for one cycle in REVIEW
    rst = 1'b0;
    tick();
    check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("mid_rst_outs", 32'(obs()), 32'd0);
    check("mid_rst_disp", {bus.disp_val, 8'(bus.disp_idx)}, 32'd0);
    rst = 1'b1;
    drive(0, 1, 0, 8'd0);
    check("clear_hi", 32'({bus.clear, bus.run}), 32'b11);
    tick();
    check("clear_lo", 32'(bus.clear), 32'd0);
    drive(1, 0, 0, 8'd0);
    check("stop_empty", 32'(dut.state_q), 32'(S_IDLE));

    // simultaneous commands in RUN
    sb.delete();
    drive(0, 1, 0, 8'd0);
    drive(0, 0, 1, 8'd7); sb.push_back(8'd7);
    drive(1, 1, 1, 8'd99);
    check("simul_state", 32'({dut.state_q, bus.run}), 32'({S_REVIEW, 1'b0}));
    check("simul_cnt", 32'(bus.lap_cnt), 32'd1);
    review_seq("simul_rev", 1);
    drive(1, 0, 0, 8'd0);
    check("rev_stop", 32'({dut.state_q, bus.lap_cnt}), 32'({S_IDLE, 3'd0}));

    // vector table: pause, fill, overflow / autostop
    sb.delete();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].stop, tbl[i].start, tbl[i].lap, tbl[i].tv);
      if (tbl[i].wr) sb.push_back(tbl[i].tv);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
`ifndef LAP_SEQ_AUTOSTOP_EN
    review_seq("full_rev", 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
